// File: rtl/vr_tooth_qualifier.sv
// Crank VR tooth qualifier: glitch filter, edge select, early-edge rejection, period and stall detect.
// Optional macro VR_EARLY_REJECT_EN enables the RUN-state ratio rejection and reject_cnt.
module vr_tooth_qualifier #(
  parameter int unsigned FILT_CYCLES     = 16,
  parameter int unsigned PERIOD_W        = 32,
  parameter int unsigned MIN_RATIO_SHIFT = 2,
  parameter int unsigned TIMEOUT         = 400000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vrin_sync,
  input  logic                edge_pol,
  output logic                tooth_pulse,
  output logic [PERIOD_W-1:0] tooth_period,
  output logic                period_valid,
  output logic                stalled,
  output logic [15:0]         reject_cnt
);

  localparam int unsigned FCNT_W = $clog2(FILT_CYCLES + 1);
  localparam logic [FCNT_W-1:0]   FILT_LAST = FCNT_W'(FILT_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FIRST = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic                filt_level_q, filt_level_d;
  logic                filt_prev_q, filt_prev_d;
  logic [FCNT_W-1:0]   filt_cnt_q, filt_cnt_d;
  logic [PERIOD_W-1:0] count_q, count_d;
  logic [1:0]          state_q, state_d;
  logic                pulse_q, pulse_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                valid_q, valid_d;
  logic                stalled_q, stalled_d;

  logic       cand_edge;
  logic       timeout;
  logic [1:0] eff_state;
  logic       accept;
  logic       early_edge;

  // Filter: the level follows only after FILT_CYCLES consecutive mismatching samples.
  always_comb begin
    filt_level_d = filt_level_q;
    filt_cnt_d   = '0;
    filt_prev_d  = filt_level_q;
    if (vrin_sync != filt_level_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_level_d = vrin_sync;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign cand_edge = (filt_level_q != filt_prev_q) && (filt_level_q == ~edge_pol);
  assign timeout   = (state_q != ST_IDLE) && (count_q >= TIMEOUT_C);
  // A timeout coinciding with an edge hands the edge to IDLE handling.
  assign eff_state = timeout ? ST_IDLE : state_q;

  always_comb begin
    state_d   = eff_state;
    stalled_d = stalled_q | timeout;
    valid_d   = valid_q & ~timeout;
    period_d  = period_q;
    accept    = 1'b0;
    if (cand_edge) begin
      case (eff_state)
        ST_IDLE: begin
          accept    = 1'b1;
          stalled_d = 1'b0;
          state_d   = ST_FIRST;
        end
        ST_FIRST: begin
          accept   = 1'b1;
          period_d = count_q;
          valid_d  = 1'b1;
          state_d  = ST_RUN;
        end
        ST_RUN: begin
          if (!early_edge) begin
            accept   = 1'b1;
            period_d = count_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    pulse_d = accept;
    if (accept) begin
      count_d = {{(PERIOD_W-1){1'b0}}, 1'b1};
    end else if (count_q >= TIMEOUT_C) begin
      count_d = count_q;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_level_q <= vrin_sync;
      filt_prev_q  <= vrin_sync;
      filt_cnt_q   <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      pulse_q      <= 1'b0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      stalled_q    <= 1'b1;
    end else begin
      filt_level_q <= filt_level_d;
      filt_prev_q  <= filt_prev_d;
      filt_cnt_q   <= filt_cnt_d;
      count_q      <= count_d;
      state_q      <= state_d;
      pulse_q      <= pulse_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      stalled_q    <= stalled_d;
    end
  end

`ifdef VR_EARLY_REJECT_EN
  logic [PERIOD_W-1:0] last_period_q, last_period_d;
  logic [15:0]         reject_q, reject_d;

  assign early_edge = count_q < (last_period_q >> MIN_RATIO_SHIFT);

  // Only RUN can reject, so a candidate there that is not accepted was early.
  always_comb begin
    last_period_d = last_period_q;
    reject_d      = reject_q;
    if (accept && (eff_state != ST_IDLE)) begin
      last_period_d = count_q;
    end
    if (cand_edge && (eff_state == ST_RUN) && early_edge && (reject_q != 16'hFFFF)) begin
      reject_d = reject_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_period_q <= '0;
      reject_q      <= '0;
    end else begin
      last_period_q <= last_period_d;
      reject_q      <= reject_d;
    end
  end

  assign reject_cnt = reject_q;
`else
  assign early_edge = 1'b0;
  assign reject_cnt = 16'd0;
`endif

  assign tooth_pulse  = pulse_q;
  assign tooth_period = period_q;
  assign period_valid = valid_q;
  assign stalled      = stalled_q;

endmodule

// File: doc/vr_tooth_qualifier.md
Name: vr_tooth_qualifier

Overview:
- Conditions the already-synchronized crank VR signal before the tooth synchronizer.
- Applies a digital glitch filter and selects the active edge polarity.
- Rejects implausibly early edges by comparing each new interval with the previous tooth period.
- Emits a one-cycle tooth pulse and measured tooth period; sync and the RPM averager consume these. A stall timeout reports loss of crank signal.

Parameters:
- FILT_CYCLES, 16, consecutive cycles a new input level must hold before the filtered level follows (min 1).
- PERIOD_W, 32, width of the period counter and tooth_period.
- MIN_RATIO_SHIFT, 2, an edge is early if its interval < last_period >> MIN_RATIO_SHIFT (default 25%).
- TIMEOUT, 400000, cycles without an accepted edge before stall (200 ms at 2 MHz).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- vrin_sync  input  1  VR comparator output, already 2-flop synchronized
- edge_pol  input  1  0 = rising edge is a tooth, 1 = falling edge; quasi-static
- tooth_pulse  output  1  one-cycle strobe per accepted tooth
- tooth_period  output  PERIOD_W  clk cycles between the last two accepted teeth
- period_valid  output  1  tooth_period holds a real measurement
- stalled  output  1  no accepted tooth for TIMEOUT cycles
- reject_cnt  output  16  saturating count of rejected early edges

Behaviour:
Reset (synchronous, takes priority over everything):
- filt_level <= vrin_sync; filter counter 0; period counter 0; state IDLE.
- Outputs: tooth_pulse 0, tooth_period 0, period_valid 0, stalled 1, reject_cnt 0.
- Reset mid-operation discards every partial interval.

Filter:
- Counter increments each cycle vrin_sync != filt_level and clears when they are equal.
- When the counter reaches FILT_CYCLES, filt_level takes the input value and the counter clears.
- A glitch shorter than FILT_CYCLES cycles never changes filt_level.

Edge detect:
- A candidate edge is a filt_level transition matching edge_pol. The opposite polarity is ignored.
- Latency: tooth_pulse rises exactly FILT_CYCLES+1 cycles after the first cycle vrin_sync shows the new level, and stays high for exactly one cycle.

Period counter:
- Increments every cycle and saturates at TIMEOUT.
- On an accepted edge it reloads to 1. tooth_period therefore equals the pulse-to-pulse distance in cycles.

State machine (IDLE, FIRST, RUN):
- IDLE, on a candidate edge: accept, pulse, clear stalled, go to FIRST. tooth_period is unchanged and period_valid stays 0.
- FIRST, on a candidate edge: accept, pulse, tooth_period <= count, last_period <= count, period_valid <= 1, go to RUN. There is no rejection in FIRST.
- RUN, candidate edge with count < (last_period >> MIN_RATIO_SHIFT): reject. No pulse, counter not reloaded, reject_cnt++ saturating at 16'hFFFF.
- RUN, candidate edge otherwise: accept. tooth_period and last_period <= count, pulse.
- A missing-tooth gap (3x period) followed by a normal tooth (1/3 of the gap) is accepted with the default shift.

Timeout:
- If count reaches TIMEOUT in FIRST or RUN: stalled <= 1, period_valid <= 0, go to IDLE. tooth_period holds its last value.
- Timeout and candidate edge in the same cycle: timeout wins. The edge is then processed as an IDLE edge, so it is accepted, pulses, and the next state is FIRST.

Widths:
- Shift and compare are unsigned at PERIOD_W. last_period >> shift never underflows.
- A count of 0 cannot occur in FIRST or RUN.

Optional Feature:
- Macro: VR_EARLY_REJECT_EN.
- Defined: RUN-state ratio rejection and reject_cnt are active as described.
- Undefined: every filtered candidate edge is accepted in RUN, reject_cnt is tied to 0, and the last_period comparator logic is not generated.

Test Plan (bench uses FILT_CYCLES=4, TIMEOUT=1000, MIN_RATIO_SHIFT=2, edge_pol=0, VR_EARLY_REJECT_EN defined):
- Glitch rejection: a 3-cycle high pulse on vrin_sync -> no tooth_pulse, filt_level unchanged. A 4-cycle high pulse -> tooth_pulse 5 cycles after its first high cycle.
- Steady teeth: rising edges every 100 cycles -> 1st pulse: period_valid 0, stalled 1->0. 2nd pulse: tooth_period=100, period_valid=1. Subsequent pulses stay at 100.
- Missing tooth: periods 100,100,300,100 -> all four accepted, tooth_period sequence 100,100,300,100, reject_cnt=0.
- Early edge: in RUN with last_period=100, extra edge 20 cycles after a tooth, then next edge at 100 -> extra edge gives no pulse, reject_cnt=1, next pulse reports tooth_period=100.
- Stall: stop edges after RUN -> stalled=1 and period_valid=0 exactly 1000 cycles after last pulse. Next edge pulses with period_valid 0, the following edge restores period_valid.
- Reset mid-run: assert reset for 1 cycle during RUN -> all outputs at reset values next cycle. The next edge is treated as an IDLE edge.
